ibex_md_sequencer: RTL

IBEX_MD_SEQUENCER -- requirements
Module: ibex_md_sequencer

---
 rtl/ibex_pkg.sv | 25 ++
 rtl/ibex_md_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ibex_pkg.sv
// Shared types and constants for the multiply/divide request sequencer.
// The state enum, the operation enum and the divide-by-zero quotient value live here.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_SEQ_IDLE = 2'd0,
        MD_SEQ_EXEC = 2'd1,
        MD_SEQ_RESP = 2'd2
    } md_seq_state_e;

    // RISC-V defines the quotient of a division by zero as all ones.
    localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ibex_md_sequencer.sv
// Sequences one multiply/divide operation at a time between the ID stage and the EX block.
// Optional: define IBEX_MD_DIV0_BYPASS_EN to answer divide/remainder by zero without using EX.
module ibex_md_sequencer
    import ibex_pkg::*;
#(
    parameter int unsigned LatW = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  md_op_e          req_op_i,
    input  logic [1:0]      req_signed_mode_i,
    input  logic [31:0]     req_op_a_i,
    input  logic [31:0]     req_op_b_i,
    input  logic            kill_i,

    output logic            mult_en_o,
    output logic            div_en_o,
    output logic            mult_sel_o,
    output logic            div_sel_o,
    output md_op_e          md_operator_o,
    output logic [1:0]      md_signed_mode_o,
    output logic [31:0]     md_op_a_o,
    output logic [31:0]     md_op_b_o,
    output logic            md_ready_id_o,

    input  logic            ex_valid_i,
    input  logic [31:0]     result_ex_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_result_o,

    output logic            busy_o,
    output logic [LatW-1:0] last_lat_o
);

    md_seq_state_e   state_reg;
    md_seq_state_e   state_next;

    md_op_e          op_reg;
    logic [1:0]      signed_mode_reg;
    logic [31:0]     op_a_reg;
    logic [31:0]     op_b_reg;
    logic [31:0]     result_reg;
    logic [LatW-1:0] lat_cnt_reg;
    logic [LatW-1:0] last_lat_reg;
    logic [LatW-1:0] lat_inc;

    logic in_idle;
    logic in_exec;
    logic in_resp;
    logic accept;
    logic ex_done;
    logic div0;
    logic op_is_div;

    assign in_idle = (state_reg == MD_SEQ_IDLE);
    assign in_exec = (state_reg == MD_SEQ_EXEC);
    assign in_resp = (state_reg == MD_SEQ_RESP);

    assign req_ready_o = in_idle | (in_resp & rsp_ready_i & ~kill_i);
    // A kill in IDLE only suppresses acceptance; in RESP it already clears req_ready_o.
    assign accept      = req_valid_i & req_ready_o & ~kill_i;
    assign ex_done     = in_exec & ex_valid_i & ~kill_i;

`ifdef IBEX_MD_DIV0_BYPASS_EN
    assign div0 = md_is_div(req_op_i) & (req_op_b_i == 32'd0);
`else
    assign div0 = 1'b0;
`endif

    assign lat_inc = (&lat_cnt_reg) ? lat_cnt_reg : lat_cnt_reg + LatW'(1);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            MD_SEQ_IDLE: begin
                if (accept) begin
                    state_next = div0 ? MD_SEQ_RESP : MD_SEQ_EXEC;
                end
            end
            MD_SEQ_EXEC: begin
                if (kill_i) begin
                    state_next = MD_SEQ_IDLE;
                end else if (ex_valid_i) begin
                    state_next = MD_SEQ_RESP;
                end
            end
            MD_SEQ_RESP: begin
                if (kill_i) begin
                    state_next = MD_SEQ_IDLE;
                end else if (rsp_ready_i) begin
                    if (accept) begin
                        state_next = div0 ? MD_SEQ_RESP : MD_SEQ_EXEC;
                    end else begin
                        state_next = MD_SEQ_IDLE;
                    end
                end
            end
            default: state_next = MD_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= MD_SEQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_reg          <= MD_OP_MULL;
            signed_mode_reg <= 2'b00;
            op_a_reg        <= 32'd0;
            op_b_reg        <= 32'd0;
        end else if (accept) begin
            op_reg          <= req_op_i;
            signed_mode_reg <= req_signed_mode_i;
            op_a_reg        <= req_op_a_i;
            op_b_reg        <= req_op_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_reg <= 32'd0;
        end else if (ex_done) begin
            result_reg <= result_ex_i;
        end else if (accept && div0) begin
            result_reg <= (req_op_i == MD_OP_DIV) ? MD_DIV0_QUOT : req_op_a_i;
        end
    end

    // The copy into last_lat includes the completing cycle itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_cnt_reg  <= '0;
            last_lat_reg <= '0;
        end else begin
            if (accept) begin
                lat_cnt_reg <= '0;
            end else if (in_exec) begin
                lat_cnt_reg <= lat_inc;
            end
            if (ex_done) begin
                last_lat_reg <= lat_inc;
            end else if (accept && div0) begin
                last_lat_reg <= '0;
            end
        end
    end

    assign op_is_div = md_is_div(op_reg);

    assign mult_sel_o       = in_exec & ~op_is_div;
    assign div_sel_o        = in_exec &  op_is_div;
    assign mult_en_o        = in_exec & ~op_is_div;
    assign div_en_o         = in_exec &  op_is_div;
    assign md_ready_id_o    = in_exec & ex_valid_i;

    assign md_operator_o    = op_reg;
    assign md_signed_mode_o = signed_mode_reg;
    assign md_op_a_o        = op_a_reg;
    assign md_op_b_o        = op_b_reg;

    assign rsp_valid_o      = in_resp;
    assign rsp_result_o     = result_reg;
    assign busy_o           = ~in_idle;
    assign last_lat_o       = last_lat_reg;

endmodule
